// File: rtl/pwm_pkg.sv
// Shared servo-PWM definitions used by both the pulse generator and the angle decoder,
// so both ends agree on the 500/2500 us pulse-width-to-angle mapping.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_state_e;

  localparam int unsigned CLK_HZ_DEF  = 50_000_000;
  localparam int unsigned ANGLE_MAX   = 180;
  localparam int unsigned DEG_DIV_DEF = 556;

  localparam int unsigned WCNT_W  = 18;
  localparam int unsigned TCNT_W  = 21;
  localparam int unsigned DEG_W   = 8;
  localparam int unsigned ANGLE_W = 9;

  function automatic int unsigned offset_cyc(input int unsigned clk_hz);
    return clk_hz / 2000;
  endfunction

  function automatic int unsigned min_cyc(input int unsigned clk_hz);
    return clk_hz / 2500;
  endfunction

  function automatic int unsigned max_cyc(input int unsigned clk_hz);
    return clk_hz * 13 / 5000;
  endfunction

  function automatic int unsigned timeout_cyc(input int unsigned clk_hz);
    return clk_hz / 40;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous servo pin, plus a delay flop
// that yields single-cycle rise/fall pulses.
module pwm_edge_sync (
  input  logic sclk,
  input  logic rst,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Flops reset high so a line already high at reset release is not seen as
  // a rise; the first partial pulse is then dropped by the decoder.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop samples its predecessor's old value.
      s1_q <= pin_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_angle_decoder.sv
// Servo pulse capture: measures the high width of each pulse and converts it to
// 0-180 degrees without a divider; flags malformed pulses and loss of signal.
module pwm_angle_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned OFFSET_CYC  = offset_cyc(CLK_HZ),
  parameter int unsigned DEG_DIV     = DEG_DIV_DEF,
  parameter int unsigned MIN_CYC     = min_cyc(CLK_HZ),
  parameter int unsigned MAX_CYC     = max_cyc(CLK_HZ),
  parameter int unsigned TIMEOUT_CYC = timeout_cyc(CLK_HZ)
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [ANGLE_W-1:0] angle,
  output logic               angle_valid,
  output logic               pulse_err,
  output logic               sig_lost
);

  localparam logic [WCNT_W-1:0] OFFSET_W   = WCNT_W'(OFFSET_CYC);
  localparam logic [WCNT_W-1:0] MIN_W      = WCNT_W'(MIN_CYC);
  localparam logic [WCNT_W-1:0] MAX_W      = WCNT_W'(MAX_CYC);
  localparam logic [WCNT_W-1:0] W_SAT      = WCNT_W'(MAX_CYC + 1);
  localparam logic [WCNT_W-1:0] HALF_W     = WCNT_W'(DEG_DIV / 2);
  localparam logic [WCNT_W-1:0] DIV_LAST_W = WCNT_W'(DEG_DIV - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_W  = TCNT_W'(TIMEOUT_CYC);
  localparam logic [DEG_W-1:0]  DEG_MAX    = DEG_W'(ANGLE_MAX);

  logic rise;
  logic fall;

  pwm_state_e          state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]   presc_q, presc_d;
  logic [DEG_W-1:0]    deg_q, deg_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  pwm_edge_sync u_edge_sync (
    .sclk   (sclk),
    .rst    (rst),
    .pin_i  (pwm_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_RISE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      WAIT_RISE: if (rise) state_d = HIGH;
      HIGH:      if (fall) state_d = LOW;
      LOW:       if (rise) state_d = HIGH;
      default:   state_d = WAIT_RISE;
    endcase
  end

  // Width counter counts the rise cycle itself, so W equals the high time.
  // The prescaler starts at DEG_DIV/2 on reaching OFFSET, rounding to nearest.
  always_comb begin
    wcnt_d  = wcnt_q;
    presc_d = presc_q;
    deg_d   = deg_q;
    if (rise) begin
      wcnt_d  = WCNT_W'(1);
      presc_d = '0;
      deg_d   = '0;
    end else if (state_q == HIGH && wcnt_q != W_SAT) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    if (state_d == HIGH && wcnt_d >= OFFSET_W) begin
      if (wcnt_d == OFFSET_W) begin
        presc_d = HALF_W;
      end else if (presc_q == DIV_LAST_W) begin
        presc_d = '0;
        if (deg_q != DEG_MAX) deg_d = deg_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (rise) begin
      tcnt_d = '0;
    end else if (tcnt_q != TIMEOUT_W) begin
      tcnt_d = tcnt_q + 1'b1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    angle_d = angle_q;
    if (state_q == HIGH && fall) begin
      if (wcnt_q < MIN_W || wcnt_q > MAX_W) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        angle_d = (wcnt_q < OFFSET_W) ? '0 : {1'b0, deg_q};
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      presc_q <= '0;
      deg_q   <= '0;
      tcnt_q  <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      presc_q <= presc_d;
      deg_q   <= deg_d;
      tcnt_q  <= tcnt_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign pulse_err   = err_q;
  assign sig_lost    = (tcnt_q == TIMEOUT_W);

endmodule

// File: tb/tb_pwm_angle_decoder.sv
// Bench for pwm_angle_decoder at a scaled clock (0.36 cycles per us) so whole
// pulse trains and the loss-of-signal timeout fit in a short run.
module tb_pwm_angle_decoder;

  localparam int OFF  = 180;   // 500 us
  localparam int DIV  = 4;     // cycles per degree
  localparam int MINC = 144;   // 400 us
  localparam int MAXC = 936;   // 2600 us
  localparam int TO   = 9000;  // 25 ms
  localparam int LOWC = 300;

  logic       sclk   = 1'b0;
  logic       rst    = 1'b1;
  logic       pwm_in = 1'b0;
  logic [8:0] angle;
  logic       angle_valid;
  logic       pulse_err;
  logic       sig_lost;

  pwm_angle_decoder #(
    .CLK_HZ      (360_000),
    .OFFSET_CYC  (OFF),
    .DEG_DIV     (DIV),
    .MIN_CYC     (MINC),
    .MAX_CYC     (MAXC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .angle       (angle),
    .angle_valid (angle_valid),
    .pulse_err   (pulse_err),
    .sig_lost    (sig_lost)
  );

  initial forever #5 sclk = ~sclk;

  int tick   = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: pin high time in cycles -> outcome, visible 2 edges after
  // the model first samples the falling pin.
  typedef struct {
    int   t;
    logic err;
    int   ang;
  } ev_t;

  ev_t  evq[$];
  int   exp_angle = 0;
  logic exp_valid = 1'b0;
  logic exp_err   = 1'b0;
  logic exp_lost  = 1'b0;

  typedef struct {
    int   t;
    logic v;
    logic e;
    int   ang;
    logic lost;
  } lit_t;

  lit_t lit [128];
  int   lit_n = 0;

  typedef struct {
    int   high;
    logic v;
    logic e;
    int   ang;
  } vec_t;

  vec_t vecs [16] = '{
    '{540,  1'b1, 1'b0, 90},
    '{180,  1'b1, 1'b0, 0},
    '{900,  1'b1, 1'b0, 180},
    '{360,  1'b1, 1'b0, 45},
    '{720,  1'b1, 1'b0, 135},
    '{162,  1'b1, 1'b0, 0},
    '{918,  1'b1, 1'b0, 180},
    '{108,  1'b0, 1'b1, 180},
    '{1080, 1'b0, 1'b1, 180},
    '{144,  1'b1, 1'b0, 0},
    '{143,  1'b0, 1'b1, 0},
    '{936,  1'b1, 1'b0, 180},
    '{937,  1'b0, 1'b1, 180},
    '{541,  1'b1, 1'b0, 90},
    '{542,  1'b1, 1'b0, 91},
    '{2,    1'b0, 1'b1, 91}
  };

  function automatic int model_angle(input int h);
    int a;
    if (h <= OFF) return 0;
    a = (h - OFF + DIV / 2) / DIV;
    return (a > 180) ? 180 : a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick);
    end
  endtask

  initial begin : model_proc
    logic prev_pin;
    logic armed;
    int   rise_t;
    int   base;
    int   pend_base;
    int   h;
    prev_pin  = 1'b1;
    armed     = 1'b0;
    rise_t    = 0;
    base      = 0;
    pend_base = -1;
    forever begin
      @(posedge sclk);
      tick++;
      if (rst) begin
        prev_pin  = 1'b1;
        armed     = 1'b0;
        base      = tick;
        pend_base = -1;
        evq.delete();
        exp_angle = 0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_lost  = 1'b0;
      end else begin
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (evq.size() > 0 && evq[0].t == tick) begin
          if (evq[0].err) exp_err = 1'b1;
          else begin
            exp_valid = 1'b1;
            exp_angle = evq[0].ang;
          end
          void'(evq.pop_front());
        end
        if (pend_base >= 0 && tick >= pend_base) begin
          base      = pend_base;
          pend_base = -1;
        end
        exp_lost = ((tick - base) >= TO);
        if (pwm_in && !prev_pin) begin
          armed     = 1'b1;
          rise_t    = tick;
          pend_base = tick + 2;
        end else if (!pwm_in && prev_pin && armed) begin
          h = tick - rise_t;
          if (h < MINC || h > MAXC) evq.push_back('{t: tick + 2, err: 1'b1, ang: 0});
          else evq.push_back('{t: tick + 2, err: 1'b0, ang: model_angle(h)});
        end
        prev_pin = pwm_in;
      end
    end
  end

  initial begin : compare_proc
    int li;
    li = 0;
    forever begin
      @(negedge sclk);
      if (rst) begin
        check("rst_angle", angle, 0);
        check("rst_valid", angle_valid, 0);
        check("rst_err", pulse_err, 0);
        check("rst_lost", sig_lost, 0);
      end else begin
        check("angle", angle, exp_angle);
        check("angle_valid", angle_valid, exp_valid);
        check("pulse_err", pulse_err, exp_err);
        check("sig_lost", sig_lost, exp_lost);
      end
      if (li < lit_n && lit[li].t == tick) begin
        check("lit_angle", angle, lit[li].ang);
        check("lit_valid", angle_valid, lit[li].v);
        check("lit_err", pulse_err, lit[li].e);
        check("lit_lost", sig_lost, lit[li].lost);
        li++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic push_lit(input int t, input logic v, input logic e, input int ang,
                          input logic lost);
    lit[lit_n] = '{t: t, v: v, e: e, ang: ang, lost: lost};
    lit_n++;
  endtask

  // Pin falls just after edge N; the registered strobe is visible after edge N+3.
  task automatic pulse(input int high, input int low, input logic v, input logic e,
                       input int ang);
    pwm_in = 1'b1;
    step(high);
    pwm_in = 1'b0;
    push_lit(tick + 3, v, e, ang, 1'b0);
    step(low);
  endtask

  initial begin : stim_proc
    int r;
    rst    = 1'b1;
    pwm_in = 1'b0;
    step(4);
    rst = 1'b0;
    step(20);

    foreach (vecs[i]) pulse(vecs[i].high, LOWC, vecs[i].v, vecs[i].e, vecs[i].ang);

    // Loss of signal after a 90 degree pulse, then recovery.
    pwm_in = 1'b1;
    r      = tick;
    step(540);
    pwm_in = 1'b0;
    push_lit(tick + 3, 1'b1, 1'b0, 90, 1'b0);
    push_lit(r + 3 + TO - 1, 1'b0, 1'b0, 90, 1'b0);
    push_lit(r + 3 + TO, 1'b0, 1'b0, 90, 1'b1);
    step(TO + 100);

    pwm_in = 1'b1;
    r      = tick;
    push_lit(r + 2, 1'b0, 1'b0, 90, 1'b1);
    push_lit(r + 3, 1'b0, 1'b0, 90, 1'b0);
    step(540);
    pwm_in = 1'b0;
    push_lit(tick + 3, 1'b1, 1'b0, 90, 1'b0);
    step(LOWC);

    // Pin high across reset release: its fall must not strobe.
    pwm_in = 1'b1;
    rst    = 1'b1;
    step(3);
    rst = 1'b0;
    step(300);
    pwm_in = 1'b0;
    push_lit(tick + 3, 1'b0, 1'b0, 0, 1'b0);
    step(LOWC);
    pulse(720, LOWC, 1'b1, 1'b0, 135);

    // Reset asserted mid-pulse, off the clock edge.
    pwm_in = 1'b1;
    step(200);
    #1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(400);
    pwm_in = 1'b0;
    push_lit(tick + 3, 1'b0, 1'b0, 0, 1'b0);
    step(LOWC);
    pulse(540, LOWC, 1'b1, 1'b0, 90);

    // Back-to-back alternating 0 / 180 degree pulses.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) pulse(180, 200, 1'b1, 1'b0, 0);
      else pulse(900, 200, 1'b1, 1'b0, 180);
    end

    step(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_angle_decoder.md
# pwm_angle_decoder

Servo-PWM capture block: samples an external 50 Hz servo pulse train on one pin and recovers the commanded angle (0–180°). It is the receive end of the pulse format our PWM generator produces. 500 µs maps to 0° and 2500 µs maps to 180°. It flags malformed pulses and loss of signal, so the angle path can be looped back and checked on-board or fed from an external servo controller.

## Interface
Parameters:
- CLK_HZ, 50_000_000: sclk frequency.
- OFFSET_CYC, CLK_HZ/2000 (25000): cycles in 500 µs, the 0° pulse width.
- DEG_DIV, 556: cycles per degree, ≈ 2000 µs × CLK_HZ / 180 / 1e6.
- MIN_CYC, CLK_HZ/2500 (20000): shortest accepted high width, 400 µs.
- MAX_CYC, CLK_HZ*13/5000 (130000): longest accepted high width, 2600 µs.
- TIMEOUT_CYC, CLK_HZ/40 (1_250_000): 25 ms without a rising edge means signal lost.

Ports:
- sclk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- pwm_in, in, 1: asynchronous servo pulse input.
- angle, out, 9: last valid decoded angle, 0–180.
- angle_valid, out, 1: one-cycle strobe when angle updates.
- pulse_err, out, 1: one-cycle strobe on a rejected pulse.
- sig_lost, out, 1: level; high while no rising edge has been seen for TIMEOUT_CYC.

## Operation
- Input conditioning:
  - pwm_in passes through a 2-FF synchronizer (s1, s2), then a delay register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states:
  - WAIT_RISE: after reset; ignores fall.
  - HIGH: on rise, clear width counter, go to HIGH. Counter increments every cycle in HIGH and saturates at MAX_CYC+1.
  - LOW: on fall in HIGH, evaluate the width W, go to LOW. On rise in LOW, go to HIGH and restart the width counter.
- Width evaluation on fall:
  - W < MIN_CYC or W > MAX_CYC: assert pulse_err; angle is unchanged.
  - Otherwise: angle = clamp(round((W − OFFSET_CYC) / DEG_DIV), 0, 180), then assert angle_valid.
  - W < OFFSET_CYC gives 0.
- Arithmetic:
  - No divider. A degree prescaler runs only while in HIGH and the width counter ≥ OFFSET_CYC.
  - The prescaler is preloaded to DEG_DIV/2 when that region starts, which gives round-to-nearest.
  - Each prescaler wrap increments an 8-bit degree accumulator; the accumulator saturates at 180.
  - The width counter is 18 bits, wide enough for MAX_CYC+1.
- Timeout:
  - A separate 21-bit counter clears on every rise and saturates at TIMEOUT_CYC.
  - sig_lost = (counter == TIMEOUT_CYC).
  - It deasserts on the cycle after the next rise. The FSM keeps running.
  - A pulse stuck high saturates the width counter; its eventual fall produces pulse_err.
- Simultaneous events: rise and fall cannot occur in the same cycle. A fall in WAIT_RISE is ignored, so the first partial pulse after reset is discarded.

## Timing
- Reset values: angle = 0, angle_valid = 0, pulse_err = 0, sig_lost = 0, FSM = WAIT_RISE, all counters = 0.
- Asserting rst mid-pulse aborts the measurement immediately and produces no strobe.
- Latency:
  - The pin edge reaches s2 in 2 cycles; rise/fall decode on cycle 3.
  - angle, angle_valid and pulse_err are registered and appear on cycle 4 after the falling edge at the pin.
- W equals the pin high time in cycles, ±1 cycle of synchronizer skew.
- Strobes are exactly one cycle wide. There is at most one strobe per pulse, and angle_valid and pulse_err are never asserted together.
- angle holds between strobes.
- sig_lost asserts TIMEOUT_CYC cycles after the last detected rise (or after reset).

## Structure
- Package pwm_pkg holds:
  - the FSM state enum (WAIT_RISE, HIGH, LOW);
  - ANGLE_MAX = 180;
  - the shared CLK_HZ-derived constants.
- The generator side uses the same package, so both ends agree on the 500/2500 µs mapping.
- One sub-module: pwm_edge_sync (2-FF synchronizer plus rise/fall detect).
- Everything else is flat.
- Target size: about 200 lines.

## Test plan
All scenarios use the default parameters, with 20 ms periods unless stated.
- Nominal pulses:
  - 1500 µs high (75000 cycles) → angle = 90, one angle_valid, 4 cycles after the fall.
  - 500 µs → 0; 2500 µs → 180; 1000 µs → 45; 2000 µs → 135. Each pulse produces exactly one strobe.
- Clamp and reject:
  - 450 µs → angle 0 with angle_valid.
  - 2550 µs → 180.
  - 300 µs → pulse_err, angle keeps its previous value.
  - 3000 µs → pulse_err.
- Signal loss:
  - Stop pulses after a 90° pulse → sig_lost rises 1_250_000 cycles after the last rise, and angle stays 90.
  - The next 1500 µs pulse drops sig_lost after its rise and strobes angle_valid.
- Reset:
  - pwm_in high at reset release → no strobe on that first fall.
  - rst asserted mid-pulse → outputs go to their reset values asynchronously.
- Glitch: a 2-cycle high spike on pwm_in → pulse_err, no angle change.
- Back-to-back pulses: alternate 0° and 180° pulses for 10 periods → the angle sequence matches exactly, with no missed strobes.
